// File: rtl/wb_arbiter_2m_if.sv
// Shared Wishbone classic bus bundle for the two-master arbiter.
// Carries both master ports (m0_*, m1_*) and the single slave port (s_*).
//   modport slave  : view taken by the arbiter. It is the target of both
//                    masters and drives the downstream slave port.
//   modport master : view taken by the environment (masters plus peripheral).
interface wb_arbiter_2m_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic          m0_we_i;
  logic          m0_cyc_i;
  logic          m0_stb_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o;
  logic          m0_err_o;

  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic          m1_we_i;
  logic          m1_cyc_i;
  logic          m1_stb_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o;
  logic          m1_err_o;

  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i;
  logic          s_we_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic          s_ack_i;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_dat_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_dat_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone classic arbiter, round-robin on ties,
// with an ack watchdog that terminates a stalled strobe with an error.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bus            : wb_arbiter_2m_if.slave (both masters + slave side)
//   grant_o        : one-hot owner, 01 = m0, 10 = m1, 00 = none
//   timeout_cnt_o  : saturating number of watchdog terminations since reset
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_arbiter_2m_if.slave        bus,
  output logic [1:0]            grant_o,
  output logic [7:0]            timeout_cnt_o
);
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned WDW = 16;
  localparam int unsigned TCW = 8;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, TERM} state_e;

  state_e         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_q, last_d;     // 1: m1 owned the bus last
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           err_q, err_d;

  logic           own_cyc_c;
  logic           own_stb_c;
  logic           own_we_c;
  logic [AW-1:0]  own_adr_c;
  logic [DW-1:0]  own_dat_c;

  // Request of the current owner (m0 unless m1 holds the grant)
  always_comb begin
    own_cyc_c = bus.m0_cyc_i;
    own_stb_c = bus.m0_stb_i;
    own_we_c  = bus.m0_we_i;
    own_adr_c = bus.m0_adr_i;
    own_dat_c = bus.m0_dat_i;
    if (grant_q[1]) begin
      own_cyc_c = bus.m1_cyc_i;
      own_stb_c = bus.m1_stb_i;
      own_we_c  = bus.m1_we_i;
      own_adr_c = bus.m1_adr_i;
      own_dat_c = bus.m1_dat_i;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Arbitration, watchdog and termination
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          grant_d = last_q ? 2'b01 : 2'b10;
          state_d = BUSY;
        end else if (bus.m0_cyc_i) begin
          grant_d = 2'b01;
          state_d = BUSY;
        end else if (bus.m1_cyc_i) begin
          grant_d = 2'b10;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc_c) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end else if (own_stb_c && !bus.s_ack_i) begin
          // An ack in the terminal-count cycle takes the else branch and wins
          if (wdog_q == WD_LAST) begin
            state_d = TERM;
            err_d   = 1'b1;
            tcnt_d  = (tcnt_q == '1) ? tcnt_q : tcnt_q + TCW'(1);
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end
      end
      TERM: begin
        if (!own_cyc_c) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Slave-side mux and ack routing; only live while BUSY so reset and
  // TERM both drop the slave cycle immediately and discard late acks
  always_comb begin
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.s_we_o   = 1'b0;
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    if (state_q == BUSY) begin
      bus.s_adr_o  = own_adr_c;
      bus.s_dat_o  = own_dat_c;
      bus.s_we_o   = own_we_c;
      bus.s_cyc_o  = own_cyc_c;
      bus.s_stb_o  = own_stb_c;
      bus.m0_ack_o = bus.s_ack_i & grant_q[0];
      bus.m1_ack_o = bus.s_ack_i & grant_q[1];
    end
  end

  assign bus.m0_dat_o  = bus.s_dat_i;
  assign bus.m1_dat_o  = bus.s_dat_i;
  assign bus.m0_err_o  = err_q & grant_q[0];
  assign bus.m1_err_o  = err_q & grant_q[1];
  assign grant_o       = grant_q;
  assign timeout_cnt_o = tcnt_q;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus randomized masters and
// slave, all compared every cycle against a transaction-level model.
module tb_wb_arbiter_2m;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic [7:0] tcnt;

  wb_arbiter_2m_if bus();

  wb_arbiter_2m #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .grant_o       (grant),
    .timeout_cnt_o (tcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current owner (-1 none), terminated flag, consecutive stalled
  // strobe cycles, pending error pulse, timeout tally, previous owner
  int m_cur, m_wait, m_tcnt, m_last;
  bit m_term, m_errp;

  // Values sampled at the last negedge
  logic [1:0]  smp_grant;
  logic        smp_scyc, smp_sstb, smp_swe, smp_sack;
  logic [15:0] smp_sadr;
  logic [7:0]  smp_sdat, smp_tcnt;
  logic        smp_a[2], smp_e[2];
  logic [7:0]  smp_d[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_wait = 0; m_tcnt = 0; m_last = 1; m_term = 0; m_errp = 0;
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [15:0] adr, input logic [7:0] dat);
    if (i == 0) begin
      bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_we_i = we;
      bus.m0_adr_i = adr; bus.m0_dat_i = dat;
    end else begin
      bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_we_i = we;
      bus.m1_adr_i = adr; bus.m1_dat_i = dat;
    end
  endtask

  // Compare DUT against model, then advance the model across the next edge
  task automatic check_model();
    logic        c[2], s[2], w[2];
    logic [15:0] a[2];
    logic [7:0]  d[2];
    logic [1:0]  eg;
    bit          live;
    logic        ecyc, estb, ewe, sack;
    logic [15:0] eadr;
    logic [7:0]  edat;
    c[0] = bus.m0_cyc_i; s[0] = bus.m0_stb_i; w[0] = bus.m0_we_i;
    a[0] = bus.m0_adr_i; d[0] = bus.m0_dat_i;
    c[1] = bus.m1_cyc_i; s[1] = bus.m1_stb_i; w[1] = bus.m1_we_i;
    a[1] = bus.m1_adr_i; d[1] = bus.m1_dat_i;
    sack = bus.s_ack_i;

    smp_grant = grant;       smp_tcnt = tcnt;
    smp_scyc = bus.s_cyc_o;  smp_sstb = bus.s_stb_o; smp_swe = bus.s_we_o;
    smp_sadr = bus.s_adr_o;  smp_sdat = bus.s_dat_o; smp_sack = sack;
    smp_a[0] = bus.m0_ack_o; smp_a[1] = bus.m1_ack_o;
    smp_e[0] = bus.m0_err_o; smp_e[1] = bus.m1_err_o;
    smp_d[0] = bus.m0_dat_o; smp_d[1] = bus.m1_dat_o;

    eg   = (m_cur < 0) ? 2'b00 : 2'(1 << m_cur);
    live = (m_cur >= 0) && !m_term;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; eadr = '0; edat = '0;
    if (live) begin
      ecyc = c[m_cur]; estb = s[m_cur]; ewe = w[m_cur];
      eadr = a[m_cur]; edat = d[m_cur];
    end
    chk("grant",  32'(smp_grant), 32'(eg));
    chk("s_cyc",  32'(smp_scyc),  32'(ecyc));
    chk("s_stb",  32'(smp_sstb),  32'(estb));
    chk("s_we",   32'(smp_swe),   32'(ewe));
    chk("s_adr",  32'(smp_sadr),  32'(eadr));
    chk("s_dat",  32'(smp_sdat),  32'(edat));
    chk("m0_ack", 32'(smp_a[0]),  32'(live && m_cur == 0 && sack));
    chk("m1_ack", 32'(smp_a[1]),  32'(live && m_cur == 1 && sack));
    chk("m0_err", 32'(smp_e[0]),  32'(m_errp && m_cur == 0));
    chk("m1_err", 32'(smp_e[1]),  32'(m_errp && m_cur == 1));
    chk("tcnt",   32'(smp_tcnt),  32'(m_tcnt));
    if (live) begin
      chk("m0_dat", 32'(smp_d[0]), 32'(bus.s_dat_i));
      chk("m1_dat", 32'(smp_d[1]), 32'(bus.s_dat_i));
    end

    m_errp = 0;
    if (m_cur < 0) begin
      m_wait = 0; m_term = 0;
      if (c[0] && c[1]) m_cur = (m_last == 0) ? 1 : 0;
      else if (c[0])    m_cur = 0;
      else if (c[1])    m_cur = 1;
    end else if (!c[m_cur]) begin
      m_last = m_cur; m_cur = -1; m_term = 0; m_wait = 0;
    end else if (!m_term) begin
      if (s[m_cur] && !sack) begin
        m_wait++;
        if (m_wait == int'(TO)) begin
          m_term = 1; m_errp = 1; m_wait = 0;
          if (m_tcnt < 255) m_tcnt++;
        end
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    set_m(0, 0, 0, 0, 16'h0, 8'h0);
    set_m(1, 0, 0, 0, 16'h0, 8'h0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int want[2];
    logic [1:0] seq[$];
    logic [1:0] exp_seq[6];
    logic [1:0] prev;
    int k;
    bit got0, early_err;
    int nleft[2];
    bit dead;

    clear_inputs();
    do_reset();

    // Reset state
    cycle();
    chk("reset_grant", 32'(smp_grant), 32'h0);
    chk("reset_scyc",  32'(smp_scyc),  32'h0);
    chk("reset_tcnt",  32'(smp_tcnt),  32'h0);

    // Single m0 write, slave acks on the third strobed cycle
    set_m(0, 1, 1, 1, 16'h1234, 8'hA5);
    cycle();
    chk("single_arb_latency", 32'(smp_grant), 32'h0);
    cycle();
    chk("single_grant", 32'(smp_grant), 32'h1);
    chk("single_adr",   32'(smp_sadr),  32'h1234);
    chk("single_dat",   32'(smp_sdat),  32'hA5);
    chk("single_we",    32'(smp_swe),   32'h1);
    chk("single_noack", 32'(smp_a[0]),  32'h0);
    cycle();
    bus.s_ack_i = 1'b1;
    cycle();
    chk("single_ack",    32'(smp_a[0]), 32'h1);
    chk("single_m1_ack", 32'(smp_a[1]), 32'h0);
    bus.s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 16'h0, 8'h0);
    cycle();
    chk("single_drop_scyc", 32'(smp_scyc), 32'h0);
    cycle();
    chk("single_idle_after", 32'(smp_grant), 32'h0);

    // Tie and fairness: three back-to-back single transfers each
    do_reset();
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    want[0] = 3; want[1] = 3; prev = 2'b00;
    set_m(0, 1, 1, 1, 16'h0100, 8'h01);
    set_m(1, 1, 1, 0, 16'h0200, 8'h02);
    for (int n = 0; n < 120; n++) begin
      cycle();
      if (smp_grant != 2'b00 && prev == 2'b00) seq.push_back(smp_grant);
      prev = smp_grant;
      bus.s_ack_i = smp_sstb && !smp_sack;
      for (int i = 0; i < 2; i++) begin
        if (smp_a[i] && ((i == 0) ? bus.m0_stb_i : bus.m1_stb_i)) begin
          set_m(i, 0, 0, 0, 16'h0, 8'h0);
          want[i]--;
        end else if (!((i == 0) ? bus.m0_cyc_i : bus.m1_cyc_i) && want[i] > 0) begin
          set_m(i, 1, 1, (i == 0), 16'(16'h0100 * (i + 1)), 8'(i + 1));
        end
      end
      if (want[0] == 0 && want[1] == 0 && smp_grant == 2'b00) break;
    end
    bus.s_ack_i = 1'b0;
    chk("tie_count", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk($sformatf("tie_order%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Hold: m1 block read of four strobes while m0 waits
    bus.s_dat_i = 8'h55;
    set_m(1, 1, 1, 0, 16'h0010, 8'h00);
    cycle();
    set_m(0, 1, 1, 1, 16'h2222, 8'h11);
    k = 0; got0 = 0;
    for (int n = 0; n < 60 && !got0; n++) begin
      cycle();
      if (k < 4) chk("hold_grant", 32'(smp_grant), 32'h2);
      if (smp_a[1] && bus.m1_stb_i) begin
        chk("hold_rdata", 32'(smp_d[1]), 32'h55);
        chk("hold_adr",   32'(smp_sadr), 32'(16'h0010 + 16'(k)));
        k++;
        if (k == 4) set_m(1, 0, 0, 0, 16'h0, 8'h0);
        else        set_m(1, 1, 1, 0, 16'h0010 + 16'(k), 8'h00);
      end
      if (smp_grant == 2'b01) got0 = 1;
      bus.s_ack_i = smp_sstb && !smp_sack;
    end
    chk("hold_strobes",  32'(k),    32'd4);
    chk("hold_m0_after", 32'(got0), 32'h1);
    bus.s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 16'h0, 8'h0);
    repeat (3) cycle();

    // Timeout: slave never acks, error on the eighth cycle after strobe
    set_m(0, 1, 1, 0, 16'h0BAD, 8'h00);
    cycle();
    early_err = 0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (smp_e[0]) early_err = 1;
    end
    chk("to_no_early_err", 32'(early_err), 32'h0);
    cycle();
    chk("to_err",  32'(smp_e[0]), 32'h1);
    chk("to_scyc", 32'(smp_scyc), 32'h0);
    chk("to_tcnt", 32'(smp_tcnt), 32'h1);
    bus.s_ack_i = 1'b1;
    cycle();
    chk("to_late_ack", 32'(smp_a[0]), 32'h0);
    chk("to_err_once", 32'(smp_e[0]), 32'h0);
    bus.s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 16'h0, 8'h0);
    repeat (3) cycle();

    // Boundary: ack in the terminal-count cycle wins
    set_m(0, 1, 1, 0, 16'h0BEE, 8'h00);
    cycle();
    for (int n = 0; n < 7; n++) cycle();
    bus.s_ack_i = 1'b1;
    cycle();
    chk("bnd_ack", 32'(smp_a[0]), 32'h1);
    chk("bnd_err", 32'(smp_e[0]), 32'h0);
    bus.s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 16'h0, 8'h0);
    cycle();
    chk("bnd_err_next", 32'(smp_e[0]), 32'h0);
    cycle();
    chk("bnd_tcnt", 32'(smp_tcnt), 32'h1);

    // Reset mid-transfer for m1
    set_m(1, 1, 1, 1, 16'h4444, 8'h44);
    cycle();
    cycle();
    chk("rst_busy_scyc", 32'(smp_scyc), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_scyc",  32'(bus.s_cyc_o), 32'h0);
    chk("rst_async_sstb",  32'(bus.s_stb_o), 32'h0);
    chk("rst_async_grant", 32'(grant),       32'h0);
    set_m(0, 1, 1, 1, 16'h5555, 8'h55);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle();
    cycle();
    chk("rst_tie_m0", 32'(smp_grant), 32'h1);
    clear_inputs();
    repeat (3) cycle();

    // Randomized traffic with periodic dead-slave windows
    nleft[0] = 0; nleft[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      dead = (n % 300) >= 250;
      bus.s_ack_i = dead ? 1'b0 : ($urandom_range(0, 99) < 35);
      bus.s_dat_i = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        logic cyc_i, stb_i;
        cyc_i = (i == 0) ? bus.m0_cyc_i : bus.m1_cyc_i;
        stb_i = (i == 0) ? bus.m0_stb_i : bus.m1_stb_i;
        if (cyc_i && smp_e[i]) begin
          set_m(i, 0, 0, 0, 16'h0, 8'h0);
        end else if (cyc_i && stb_i && smp_a[i]) begin
          nleft[i]--;
          if (nleft[i] == 0) set_m(i, 0, 0, 0, 16'h0, 8'h0);
          else set_m(i, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     16'($urandom), 8'($urandom));
        end else if (cyc_i && !stb_i) begin
          if ($urandom_range(0, 1) == 1)
            set_m(i, 1, 1, $urandom_range(0, 1) == 1, 16'($urandom), 8'($urandom));
        end else if (!cyc_i && $urandom_range(0, 99) < 20) begin
          nleft[i] = $urandom_range(1, 4);
          set_m(i, 1, 1, $urandom_range(0, 1) == 1, 16'($urandom), 8'($urandom));
        end
      end
    end
    clear_inputs();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
